iir_band_scan: RTL
==================

// Module: iir_band_scan
// PURPOSE
//  Downstream of the 2nd-order bandpass IIR stage. Sweeps the filter's band index over all bands.
//  For each band it discards settling samples, then tracks peak |dout_W| over a window, and reports
//  the band with the largest peak. After a scan the index stays parked on the winning band.
// PARAMETERS
//  W        20    sample width; matches the filter's wide output dout_W (signed)
//  NBANDS   20    number of centre-frequency bands (filter coefficient table depth)
//  SETTLE_N 256   en-qualified samples discarded after each index change
//  WIN_N    1024  en-qualified samples measured per band
// PORTS
//  clk         in   1      single clock
//  rst_n       in   1      asynchronous active-low reset
//  en          in   1      sample strobe; din is valid in cycles where en=1
//  din         in   W      signed filter output sample
//  start       in   1      begin scan (sampled in IDLE only)
//  index       out  32     band select to the filter; zero-extended band counter
//  busy        out  1      high from the cycle after start until done
//  done        out  1      1-cycle pulse when the scan completes
//  band_valid  out  1      1-cycle pulse per band with band_id/band_amp
//  band_id     out  5      band just measured
//  band_amp    out  W      peak |din| of that band (unsigned magnitude, MSB=0)
//  best_index  out  5      winning band of the last completed scan
//  best_amp    out  W      peak of the winning band
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0, state IDLE, counters and peak cleared.
//  States: IDLE -> SETTLE -> MEASURE -> COMPARE -> (SETTLE | DONE) -> IDLE.
//  IDLE: start=1 -> band=0, index=0, best_amp=0, busy=1, goto SETTLE. Other inputs ignored.
//  SETTLE: count en samples; after SETTLE_N, clear peak, goto MEASURE. din is ignored.
//  MEASURE: on each en, peak <= max(peak, abs_sat(din)). After WIN_N samples goto COMPARE.
//  abs_sat: |x|. The most negative value -2^(W-1) maps to 2^(W-1)-1 (saturate, never wraps).
//  COMPARE (1 cycle): band_valid=1, band_id=band, band_amp=peak.
//    If peak > best_amp (strict), update best_index/best_amp, so ties keep the lower band.
//    If band==NBANDS-1 goto DONE; else band+1, index updates this cycle, goto SETTLE.
//  DONE (1 cycle): done=1, busy=0, index<=best_index (parked), goto IDLE.
//  en=0 stalls all counting; no timeout.
//  start while busy is ignored; start in the DONE cycle is ignored.
//  Scan length = NBANDS*(SETTLE_N+WIN_N) en samples + NBANDS COMPARE cycles + 1 DONE cycle.
//  best_index/best_amp hold their values between scans and are overwritten during a scan.
//  Counters sized $clog2(max(SETTLE_N,WIN_N)+1) and wrap-free.
//  The band counter never exceeds NBANDS-1.
//  Reset mid-scan: immediate return to IDLE with all outputs 0; no done pulse.
// STRUCTURE
//  Package iir_scan_pkg contains:
//    - scan_state_e enum {IDLE,SETTLE,MEASURE,COMPARE,DONE}
//    - BAND_W=5
//    - function abs_sat(logic signed [W-1:0])
//  Sub-module peak_abs_tracker(clk,rst_n,clr,en,din,peak) holds the abs_sat and running max.
//  The top level holds the FSM, sample counter, band counter and best registers.
// TESTING (bench params NBANDS=4, SETTLE_N=4, WIN_N=8, W=20; en=1 every 2nd cycle)
//  1 Reset: rst_n=0 -> index=0, busy=0, done=0, best_amp=0.
//    Pulsing start with rst_n=0 starts nothing.
//  2 Constant |din| per band = 100, 300, 900, 200 -> four band_valid pulses with those amps.
//    Then done pulse, best_index=2, best_amp=900, index=2.
//  3 Band 0 din=-524288 in MEASURE -> band_amp=524287.
//    Settle-only spike: band 1 din=40000 during SETTLE, 10 in MEASURE -> band_amp=10.
//  4 Tie: bands 1 and 3 both peak 500, others 50 -> best_index=1, best_amp=500.
//  5 start re-pulsed mid-scan and en held low 20 cycles -> scan completes once with no lost
//    samples. Total en count to done = 4*12.
//  6 rst_n dropped during band 2 MEASURE -> outputs 0 in same cycle (async), no done.
//    A new start then completes a full scan correctly.

Source files
------------

// File: rtl/iir_scan_pkg.sv
// iir_scan_pkg: shared state encoding, widths and saturating magnitude for the band scanner
package iir_scan_pkg;
  localparam int BAND_W = 5;
  localparam int SAMPLE_W = 20;
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, DONE} scan_state_e;
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] n;
    n = -x;
    return (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) ? {1'b0, {(SAMPLE_W-1){1'b1}}} : (x[SAMPLE_W-1] ? n : x);
  endfunction
endpackage

// File: rtl/peak_abs_tracker.sv
// peak_abs_tracker: running maximum of saturated |din| over en-qualified samples
module peak_abs_tracker
  import iir_scan_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] peak
);
  logic [W-1:0] mag;
  assign mag = abs_sat(din);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) peak <= '0;
    else if (clr) peak <= '0;
    else if (en && mag > peak) peak <= mag;
endmodule

// File: rtl/iir_band_scan.sv
// iir_band_scan: sweeps filter bands, measures peak magnitude per band and parks on the loudest
module iir_band_scan
  import iir_scan_pkg::*;
#(
  parameter int W        = SAMPLE_W,
  parameter int NBANDS   = 20,
  parameter int SETTLE_N = 256,
  parameter int WIN_N    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [W-1:0]      din,
  input  logic              start,
  output logic [31:0]       index,
  output logic              busy,
  output logic              done,
  output logic              band_valid,
  output logic [BAND_W-1:0] band_id,
  output logic [W-1:0]      band_amp,
  output logic [BAND_W-1:0] best_index,
  output logic [W-1:0]      best_amp
);
  localparam int CNT_W = $clog2((SETTLE_N > WIN_N ? SETTLE_N : WIN_N) + 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_N - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_N - 1);
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NBANDS - 1);
  scan_state_e state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [BAND_W-1:0] band;
  logic [W-1:0] peak;
  logic set_end, win_end, counting;
  assign counting = state == SETTLE || state == MEASURE;
  assign set_end  = state == SETTLE && en && cnt == SET_LAST;
  assign win_end  = state == MEASURE && en && cnt == WIN_LAST;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? SETTLE : IDLE;
      SETTLE:  nxt = set_end ? MEASURE : SETTLE;
      MEASURE: nxt = win_end ? COMPARE : MEASURE;
      COMPARE: nxt = band == LAST_BAND ? DONE : SETTLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      band       <= '0;
      best_index <= '0;
      best_amp   <= '0;
    end else begin
      cnt <= (!counting || set_end || win_end) ? '0 : cnt + CNT_W'(en);
      if (state == IDLE && start) begin
        band       <= '0;
        best_index <= '0;
        best_amp   <= '0;
      end
      // strict compare: an equal later peak leaves the lower band as winner
      if (state == COMPARE) begin
        if (peak > best_amp) begin
          best_index <= band;
          best_amp   <= peak;
        end
        if (band != LAST_BAND) band <= band + 1'b1;
      end
      if (state == DONE) band <= best_index;
    end
  peak_abs_tracker #(.W(W)) u_peak (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (set_end),
    .en   (en && state == MEASURE),
    .din  (din),
    .peak (peak)
  );
  assign index      = 32'(band);
  assign busy       = counting || state == COMPARE;
  assign done       = state == DONE;
  assign band_valid = state == COMPARE;
  assign band_id    = band;
  assign band_amp   = peak;
endmodule
